// File: rtl/qupls4_pkg.sv
// Shared types for the QUPLS4 checkpoint release controller.
// The optional statistics counters are enabled with QUPLS4_CHKPT_STATS_EN.
package qupls4_pkg;

    localparam int NCHECK = 16;
    localparam int CHK_W  = $clog2(NCHECK);

    typedef logic [CHK_W-1:0] checkpt_ndx_t;

    typedef enum logic [2:0] {
        FREE      = 3'd0,
        LIVE      = 3'd1,
        MISS_PEND = 3'd2,
        RESTORING = 3'd3
    } chkpt_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2
    } chkpt_rst_fsm_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction

endpackage

// File: rtl/qupls4_chkpt_ffo.sv
// Find-first-one: returns the lowest set bit index of vec and whether any bit is set.
module qupls4_chkpt_ffo #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] ndx,
    output logic         found
);

    always_comb begin
        ndx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                ndx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qupls4_checkpoint_release_ctrl.sv
// Branch checkpoint lifetime tracker, mispredict restore arbiter and free-bitmap generator.
// Define QUPLS4_CHKPT_STATS_EN to add the stat_frees / stat_restores counters.
module qupls4_checkpoint_release_ctrl
    import qupls4_pkg::*;
#(
    parameter int NCHECK = qupls4_pkg::NCHECK,
    parameter int NRES   = 2,
    localparam int W     = $clog2(NCHECK)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_v,
    input  logic [W-1:0]           alloc_ndx,
    input  logic [NRES-1:0]        res_v,
    input  logic [NRES-1:0][W-1:0] res_ndx,
    input  logic [NRES-1:0]        res_miss,
    input  logic                   flush_all,
    output logic                   restore_v,
    output logic [W-1:0]           restore_ndx,
    input  logic                   restore_done,
    output logic [NCHECK-1:0]      chkpts_to_free,
    output logic                   busy,
    output logic                   err
`ifdef QUPLS4_CHKPT_STATS_EN
    ,
    output logic [31:0]            stat_frees,
    output logic [31:0]            stat_restores
`endif
);

    chkpt_state_t      st     [NCHECK];
    chkpt_state_t      st_nxt [NCHECK];
    chkpt_rst_fsm_t    fsm, fsm_nxt;
    logic [W-1:0]      restore_ndx_nxt;
    logic [NCHECK-1:0] free_nxt;
    logic [NCHECK-1:0] pend_vec;
    logic              err_nxt;
    logic [W-1:0]      ffo_ndx;
    logic              ffo_found;
    logic              res_hit;
    logic              res_sel_miss;

    always_comb begin
        for (int i = 0; i < NCHECK; i++) begin
            pend_vec[i] = (st[i] == MISS_PEND);
        end
    end

    qupls4_chkpt_ffo #(.N(NCHECK)) u_ffo (
        .vec   (pend_vec),
        .ndx   (ffo_ndx),
        .found (ffo_found)
    );

    always_comb begin
        st_nxt          = st;
        fsm_nxt         = fsm;
        restore_ndx_nxt = restore_ndx;
        free_nxt        = '0;
        err_nxt         = err;
        res_hit         = 1'b0;
        res_sel_miss    = 1'b0;

        for (int i = 0; i < NCHECK; i++) begin
            // Lowest-numbered port wins when several resolve the same checkpoint.
            res_hit      = 1'b0;
            res_sel_miss = 1'b0;
            for (int p = 0; p < NRES; p++) begin
                if (res_v[p] && res_ndx[p] == W'(i)) begin
                    if (res_hit) begin
                        err_nxt = 1'b1;
                    end else begin
                        res_hit      = 1'b1;
                        res_sel_miss = res_miss[p];
                    end
                end
            end

            if (flush_all && (st[i] == LIVE || st[i] == MISS_PEND)) begin
                st_nxt[i]   = FREE;
                free_nxt[i] = 1'b1;
            end else if (res_hit) begin
                if (st[i] == LIVE) begin
                    if (res_sel_miss) begin
                        st_nxt[i] = MISS_PEND;
                    end else begin
                        st_nxt[i]   = FREE;
                        free_nxt[i] = 1'b1;
                    end
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (alloc_v && alloc_ndx == W'(i)) begin
                if (st[i] == FREE && i != 0) begin
                    st_nxt[i] = LIVE;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end

        // A flush is discarding every pending miss this cycle, so nothing is picked.
        unique case (fsm)
            R_IDLE: begin
                if (ffo_found && !flush_all) begin
                    fsm_nxt          = R_ISSUE;
                    restore_ndx_nxt  = ffo_ndx;
                    st_nxt[ffo_ndx]  = RESTORING;
                end
            end
            R_ISSUE: fsm_nxt = R_WAIT;
            R_WAIT: begin
                if (restore_done) begin
                    fsm_nxt               = R_IDLE;
                    st_nxt[restore_ndx]   = FREE;
                    free_nxt[restore_ndx] = 1'b1;
                end
            end
            default: fsm_nxt = R_IDLE;
        endcase

        if (restore_done && fsm != R_WAIT) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st             <= '{default: FREE};
            fsm            <= R_IDLE;
            restore_ndx    <= '0;
            chkpts_to_free <= '0;
            err            <= 1'b0;
        end else begin
            st             <= st_nxt;
            fsm            <= fsm_nxt;
            restore_ndx    <= restore_ndx_nxt;
            chkpts_to_free <= free_nxt;
            err            <= err_nxt;
        end
    end

    assign restore_v = (fsm == R_ISSUE);
    assign busy      = (fsm != R_IDLE);

`ifdef QUPLS4_CHKPT_STATS_EN
    logic [31:0] free_cnt;

    always_comb free_cnt = 32'($countones(chkpts_to_free));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_frees    <= '0;
            stat_restores <= '0;
        end else begin
            stat_frees    <= sat_add32(stat_frees, free_cnt);
            stat_restores <= sat_add32(stat_restores, {31'd0, restore_v});
        end
    end
`endif

endmodule

// File: tb/tb_qupls4_checkpoint_release_ctrl.sv
// Directed plus randomized bench for qupls4_checkpoint_release_ctrl against a set-based reference model.
// Also checks the statistics counters when QUPLS4_CHKPT_STATS_EN is defined.
module tb_qupls4_checkpoint_release_ctrl;

    localparam int NC = 16;
    localparam int NR = 2;
    localparam int W  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_v;
    logic [W-1:0]         alloc_ndx;
    logic [NR-1:0]        res_v;
    logic [NR-1:0][W-1:0] res_ndx;
    logic [NR-1:0]        res_miss;
    logic                 flush_all;
    logic                 restore_v;
    logic [W-1:0]         restore_ndx;
    logic                 restore_done;
    logic [NC-1:0]        chkpts_to_free;
    logic                 busy;
    logic                 err;
`ifdef QUPLS4_CHKPT_STATS_EN
    logic [31:0]          stat_frees;
    logic [31:0]          stat_restores;
`endif

    qupls4_checkpoint_release_ctrl #(.NCHECK(NC), .NRES(NR)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_v        (alloc_v),
        .alloc_ndx      (alloc_ndx),
        .res_v          (res_v),
        .res_ndx        (res_ndx),
        .res_miss       (res_miss),
        .flush_all      (flush_all),
        .restore_v      (restore_v),
        .restore_ndx    (restore_ndx),
        .restore_done   (restore_done),
        .chkpts_to_free (chkpts_to_free),
        .busy           (busy),
        .err            (err)
`ifdef QUPLS4_CHKPT_STATS_EN
        ,
        .stat_frees     (stat_frees),
        .stat_restores  (stat_restores)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sets of live / pending checkpoints, one checkpoint under restore,
    // and a restore phase (0 idle, 1 pulse cycle, 2 waiting for done).
    bit          m_live [NC];
    bit          m_pend [NC];
    int          m_rest;
    int          m_phase;
    logic [NC-1:0] m_free;
    logic [W-1:0]  m_rndx;
    logic          m_err;
    logic [31:0]   m_sf;
    logic [31:0]   m_sr;

    function automatic logic [31:0] sat(input logic [31:0] a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > 64'h0000_0000_ffff_ffff) ? 32'hffff_ffff : s[31:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_live[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_rest  = -1;
        m_phase = 0;
        m_free  = '0;
        m_rndx  = '0;
        m_err   = 1'b0;
        m_sf    = '0;
        m_sr    = '0;
    endfunction

    function automatic void model_step();
        bit            nl   [NC];
        bit            np   [NC];
        bit            seen [NC];
        logic [NC-1:0] f;
        int            n;
        int            pick;
        int            phase_old;
        nl   = m_live;
        np   = m_pend;
        f    = '0;
        pick = -1;
        for (int i = 0; i < NC; i++) seen[i] = 1'b0;
        phase_old = m_phase;

        m_sf = sat(m_sf, $countones(m_free));
        m_sr = sat(m_sr, (m_phase == 1) ? 1 : 0);

        if (flush_all) begin
            for (int i = 0; i < NC; i++) begin
                if (m_live[i] || m_pend[i]) begin
                    f[i]  = 1'b1;
                    nl[i] = 1'b0;
                    np[i] = 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (res_v[p]) begin
                    n = int'(res_ndx[p]);
                    if (seen[n]) m_err = 1'b1;
                    else begin
                        seen[n] = 1'b1;
                        if (m_live[n]) begin
                            nl[n] = 1'b0;
                            if (res_miss[p]) np[n] = 1'b1;
                            else f[n] = 1'b1;
                        end else m_err = 1'b1;
                    end
                end
            end
        end

        if (alloc_v) begin
            n = int'(alloc_ndx);
            if (flush_all && (m_live[n] || m_pend[n])) begin
                // the flush claims this index
            end else if (n == 0 || m_live[n] || m_pend[n] || m_rest == n) m_err = 1'b1;
            else nl[n] = 1'b1;
        end

        if (m_phase == 0) begin
            if (!flush_all) begin
                for (int i = 0; i < NC; i++) if (m_pend[i] && pick < 0) pick = i;
                if (pick >= 0) begin
                    np[pick] = 1'b0;
                    m_rest   = pick;
                    m_rndx   = W'(pick);
                    m_phase  = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (restore_done) begin
            f[m_rest] = 1'b1;
            m_rest    = -1;
            m_phase   = 0;
        end
        if (restore_done && phase_old != 2) m_err = 1'b1;

        m_live = nl;
        m_pend = np;
        m_free = f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".free"}, 32'(chkpts_to_free), 32'(m_free));
        check({tag, ".restore_v"}, 32'(restore_v), (m_phase == 1) ? 32'd1 : 32'd0);
        check({tag, ".restore_ndx"}, 32'(restore_ndx), 32'(m_rndx));
        check({tag, ".busy"}, 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
        check({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef QUPLS4_CHKPT_STATS_EN
        check({tag, ".stat_frees"}, stat_frees, m_sf);
        check({tag, ".stat_restores"}, stat_restores, m_sr);
`endif
    endtask

    task automatic idle_inputs();
        alloc_v      = 1'b0;
        alloc_ndx    = '0;
        res_v        = '0;
        res_ndx      = '0;
        res_miss     = '0;
        flush_all    = 1'b0;
        restore_done = 1'b0;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    task automatic do_alloc(input int n);
        alloc_v   = 1'b1;
        alloc_ndx = W'(n);
        tick("alloc");
    endtask

    task automatic random_phase(input int ncyc);
        int n;
        int used;
        for (int c = 0; c < ncyc; c++) begin
            used = -1;
            if ($urandom_range(0, 19) == 0) flush_all = 1'b1;
            else begin
                for (int p = 0; p < NR; p++) begin
                    if ($urandom_range(0, 9) < 4) begin
                        n = int'($urandom_range(1, NC - 1));
                        if (m_live[n] && n != used) begin
                            res_v[p]    = 1'b1;
                            res_ndx[p]  = W'(n);
                            res_miss[p] = 1'($urandom_range(0, 1));
                            used        = n;
                        end
                    end
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                n = int'($urandom_range(1, NC - 1));
                if (!m_live[n] && !m_pend[n] && m_rest != n) begin
                    alloc_v   = 1'b1;
                    alloc_ndx = W'(n);
                end
            end
            if (m_phase == 2 && $urandom_range(0, 2) == 0) restore_done = 1'b1;
            tick("rand");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.free", 32'(chkpts_to_free), 32'h0);
        check("reset.restore_v", 32'(restore_v), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.err", 32'(err), 32'h0);
        check_all("reset");
        @(negedge clk) rst = 1'b1;

        // Correct prediction frees the checkpoint for exactly one cycle.
        do_alloc(3);
        tick("gap");
        res_v[0] = 1'b1; res_ndx[0] = 4'd3; res_miss[0] = 1'b0;
        tick("res3");
        check("t1.free", 32'(chkpts_to_free), 32'h0008);
        check("t1.restore_v", 32'(restore_v), 32'h0);
        tick("t1.after");
        check("t1.free_clear", 32'(chkpts_to_free), 32'h0);

        // Two mispredicts in one cycle are restored lowest index first.
        do_alloc(5);
        do_alloc(9);
        res_v = 2'b11; res_ndx[0] = 4'd9; res_ndx[1] = 4'd5; res_miss = 2'b11;
        tick("miss2");
        tick("pend");
        check("t2.restore_v", 32'(restore_v), 32'h1);
        check("t2.restore_ndx", 32'(restore_ndx), 32'h5);
        tick("wait5");
        restore_done = 1'b1;
        tick("done5");
        check("t2.free5", 32'(chkpts_to_free), 32'h0020);
        tick("idle");
        check("t2.restore_ndx9", 32'(restore_ndx), 32'h9);
        check("t2.restore_v9", 32'(restore_v), 32'h1);
        tick("wait9");
        restore_done = 1'b1;
        tick("done9");
        check("t2.free9", 32'(chkpts_to_free), 32'h0200);

        // Flush spares the restoring checkpoint and a same-cycle allocation.
        do_alloc(2);
        do_alloc(4);
        do_alloc(6);
        res_v[0] = 1'b1; res_ndx[0] = 4'd4; res_miss[0] = 1'b1;
        tick("miss4");
        tick("issue4");
        flush_all = 1'b1; alloc_v = 1'b1; alloc_ndx = 4'd7;
        tick("flush");
        check("t3.flush_free", 32'(chkpts_to_free), 32'h0044);
        res_v[0] = 1'b1; res_ndx[0] = 4'd7; res_miss[0] = 1'b0;
        tick("res7");
        check("t3.free7", 32'(chkpts_to_free), 32'h0080);
        check("t3.err", 32'(err), 32'h0);
        restore_done = 1'b1;
        tick("done4");
        check("t3.free4", 32'(chkpts_to_free), 32'h0010);

        random_phase(400);

        flush_all = 1'b1;
        tick("drain_flush");
        for (int k = 0; k < 8 && m_phase != 0; k++) begin
            restore_done = (m_phase == 2);
            tick("drain");
        end
        check("drain.busy", 32'(busy), 32'h0);

        // Protocol errors are sticky.
        res_v[0] = 1'b1; res_ndx[0] = 4'd8; res_miss[0] = 1'b0;
        tick("res8");
        check("t4.err", 32'(err), 32'h1);
        check("t4.free", 32'(chkpts_to_free), 32'h0);
        tick("t4.hold");
        check("t4.err_sticky", 32'(err), 32'h1);
        do_alloc(0);

        // Asynchronous reset in the middle of a restore.
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk) rst = 1'b1;
        do_alloc(1);
        res_v[0] = 1'b1; res_ndx[0] = 4'd1; res_miss[0] = 1'b1;
        tick("miss1");
        tick("issue1");
        tick("wait1");
        check("t5.busy", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t5.restore_v", 32'(restore_v), 32'h0);
        check("t5.busy0", 32'(busy), 32'h0);
        check("t5.err0", 32'(err), 32'h0);
        check("t5.free0", 32'(chkpts_to_free), 32'h0);
        check("t5.ndx0", 32'(restore_ndx), 32'h0);
        @(negedge clk) rst = 1'b1;
        restore_done = 1'b1;
        tick("t5.done");
        check("t5.err1", 32'(err), 32'h1);
        check("t5.idle", 32'(busy), 32'h0);
        tick("t5.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
